// File: rtl/wb_echo_capture_pkg.sv
// Shared definitions for the echo pulse-width capture block:
// register map, CTRL bit positions, FSM encoding, default timeout.
package wb_echo_capture_pkg;

   localparam logic [1:0] reg_ctrl    = 2'd0;
   localparam logic [1:0] reg_width   = 2'd1;
   localparam logic [1:0] reg_timeout = 2'd2;
   localparam logic [1:0] reg_count   = 2'd3;

   localparam int ctrl_arm      = 0;
   localparam int ctrl_clr_done = 1;
   localparam int ctrl_clr_to   = 2;
   localparam int ctrl_busy     = 3;
   localparam int ctrl_irq_en   = 4;
   localparam int ctrl_auto_arm = 5;

   typedef enum logic [1:0] {
      st_idle      = 2'd0,
      st_wait_rise = 2'd1,
      st_measure   = 2'd2,
      st_done      = 2'd3
   } state_t;

   // 40 ms worth of clock cycles
   function automatic int unsigned default_timeout(input int unsigned freq);
      return freq / 25;
   endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Optional 2-FF synchroniser followed by a one-flop edge detector.
// rise/fall are one-cycle pulses derived from the (synchronised) level.
module echo_sync_edge #(
   parameter bit sync = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   logic prev;

   generate
      if (sync) begin : g_sync
         logic s1;
         logic s2;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1 <= 1'b0;
               s2 <= 1'b0;
            end else begin
               s1 <= sig;
               s2 <= s1;
            end
         end
         assign level = s2;
      end else begin : g_bypass
         assign level = sig;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= level;
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/wb_echo_capture.sv
// Wishbone slave measuring the high-pulse width of the ultrasonic
// echo line in clock cycles, with timeout and completion interrupt.
module wb_echo_capture
   import wb_echo_capture_pkg::*;
#(
   parameter int unsigned clk_freq        = 50000000,
   parameter int unsigned timeout_default = default_timeout(clk_freq),
   parameter int unsigned cnt_width       = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic        echo_i,
   input  logic        trig_i,
   output logic        intr
);

   localparam logic [cnt_width-1:0] one = cnt_width'(1);

   state_t               state;
   logic [cnt_width-1:0] count;
   logic [cnt_width-1:0] tcnt;
   logic [cnt_width-1:0] width;
   logic [cnt_width-1:0] timeout_reg;
   logic [cnt_width-1:0] tlim;
   logic                 done;
   logic                 to_flag;
   logic                 to_pend;
   logic                 irq_en;
   logic                 auto_arm;

   logic echo_level, echo_rise, echo_fall;
   logic trig_level, trig_rise, trig_fall;

   logic        req, wr, rd, ctrl_wr, arm, expire, busy;
   logic [1:0]  adr;
   logic [31:0] rdata;
   logic [31:0] t_new;
   logic        unused;

   echo_sync_edge #(.sync(1'b1)) u_echo (
      .clk   (clk),
      .reset (reset),
      .sig   (echo_i),
      .level (echo_level),
      .rise  (echo_rise),
      .fall  (echo_fall)
   );

   // trig_i is already in the clk domain
   echo_sync_edge #(.sync(1'b0)) u_trig (
      .clk   (clk),
      .reset (reset),
      .sig   (trig_i),
      .level (trig_level),
      .rise  (trig_rise),
      .fall  (trig_fall)
   );

   function automatic logic [cnt_width-1:0] sat_inc(
      input logic [cnt_width-1:0] v
   );
      return (&v) ? v : v + one;
   endfunction

   assign adr     = wb_adr_i[3:2];
   assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign wr      = req & wb_we_i;
   assign rd      = req & ~wb_we_i;
   assign ctrl_wr = wr && (adr == reg_ctrl);
   assign busy    = (state != st_idle);
   assign arm     = ~busy & ((ctrl_wr & wb_dat_i[ctrl_arm])
                           | (auto_arm & trig_fall));
   assign tlim    = (timeout_reg == '0) ? '1 : timeout_reg;
   assign expire  = (tcnt >= tlim - one);
   assign intr    = done & irq_en;
   assign unused  = ^{wb_adr_i[31:4], wb_adr_i[1:0], trig_level, trig_rise};

   always_comb begin
      t_new = 32'(timeout_reg);
      for (int b = 0; b < 4; b++) begin
         if (wb_sel_i[b]) t_new[8*b +: 8] = wb_dat_i[8*b +: 8];
      end
   end

   always_comb begin
      rdata = '0;
      unique case (adr)
         reg_ctrl: begin
            rdata[ctrl_clr_done] = done;
            rdata[ctrl_clr_to]   = to_flag;
            rdata[ctrl_busy]     = busy;
            rdata[ctrl_irq_en]   = irq_en;
            rdata[ctrl_auto_arm] = auto_arm;
         end
         reg_width:   rdata = 32'(width);
         reg_timeout: rdata = 32'(timeout_reg);
         reg_count:   rdata = 32'(count);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         state       <= st_idle;
         count       <= '0;
         tcnt        <= '0;
         width       <= '0;
         timeout_reg <= cnt_width'(timeout_default);
         done        <= 1'b0;
         to_flag     <= 1'b0;
         to_pend     <= 1'b0;
         irq_en      <= 1'b0;
         auto_arm    <= 1'b0;
      end else begin
         wb_ack_o <= req;
         if (rd) wb_dat_o <= rdata;

         if (ctrl_wr) begin
            irq_en   <= wb_dat_i[ctrl_irq_en];
            auto_arm <= wb_dat_i[ctrl_auto_arm];
            if (wb_dat_i[ctrl_clr_done]) done    <= 1'b0;
            if (wb_dat_i[ctrl_clr_to])   to_flag <= 1'b0;
         end
         if (wr && adr == reg_timeout) timeout_reg <= t_new[cnt_width-1:0];
         if (rd && adr == reg_width)   done <= 1'b0;

         // Flag sets below come last so they win over same-cycle clears
         unique case (state)
            st_idle: begin
               if (arm) begin
                  count   <= '0;
                  tcnt    <= '0;
                  done    <= 1'b0;
                  to_flag <= 1'b0;
                  to_pend <= 1'b0;
                  state   <= st_wait_rise;
               end
            end
            st_wait_rise: begin
               if (expire) begin
                  to_pend <= 1'b1;
                  state   <= st_done;
               end else begin
                  tcnt <= sat_inc(tcnt);
                  if (echo_rise) begin
                     count <= one;
                     state <= st_measure;
                  end else begin
                     count <= sat_inc(count);
                  end
               end
            end
            st_measure: begin
               if (expire) begin
                  to_pend <= 1'b1;
                  state   <= st_done;
               end else begin
                  tcnt <= sat_inc(tcnt);
                  if (echo_fall) begin
                     width <= count;
                     state <= st_done;
                  end else if (echo_level) begin
                     count <= sat_inc(count);
                  end
               end
            end
            st_done: begin
               done <= 1'b1;
               if (to_pend) begin
                  to_flag <= 1'b1;
                  width   <= '1;
               end
               state <= st_idle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_echo_capture.sv
// Directed bench for wb_echo_capture: register table plus
// hand-written pulse, timeout, auto-arm and reset sequences.
module tb_wb_echo_capture;

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_WID  = 2'd1;
   localparam logic [1:0] A_TO   = 2'd2;
   localparam logic [1:0] A_CNT  = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic        wb_ack_o;
   logic        echo_i = 1'b0;
   logic        trig_i = 1'b0;
   logic        intr;

   int n_checks = 0;
   int n_fail = 0;
   int cyc_cnt = 0;
   int last_ack = 0;

   wb_echo_capture dut (
      .clk      (clk),
      .reset    (reset),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_we_i  (wb_we_i),
      .wb_ack_o (wb_ack_o),
      .echo_i   (echo_i),
      .trig_i   (trig_i),
      .intr     (intr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic        we;
      logic [1:0]  idx;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[14];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [1:0] idx,
                       input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rdata);
      int n;
      @(negedge clk);
      wb_adr_i = {28'd0, idx, 2'b00};
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wb_ack_o && n < 20);
      if (!wb_ack_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: no ack after %0d cycles", n);
      end
      last_ack = cyc_cnt;
      rdata = wb_dat_o;
      @(negedge clk);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] dat);
      logic [31:0] d;
      xfer(1'b1, idx, dat, 4'hF, d);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] idx,
                         input logic [31:0] exp);
      logic [31:0] d;
      xfer(1'b0, idx, 32'd0, 4'hF, d);
      check(name, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int t0;
      int delta;
      bit  seen;

      vt[0]  = '{1'b0, A_CTRL, 32'h0,        4'hF, 32'h0};
      vt[1]  = '{1'b0, A_WID,  32'h0,        4'hF, 32'h0};
      vt[2]  = '{1'b0, A_TO,   32'h0,        4'hF, 32'h001E8480};
      vt[3]  = '{1'b0, A_CNT,  32'h0,        4'hF, 32'h0};
      vt[4]  = '{1'b1, A_TO,   32'h12345678, 4'h5, 32'h0};
      vt[5]  = '{1'b0, A_TO,   32'h0,        4'hF, 32'h00348478};
      vt[6]  = '{1'b1, A_TO,   32'hAABBCCDD, 4'hA, 32'h0};
      vt[7]  = '{1'b0, A_TO,   32'h0,        4'hF, 32'hAA34CC78};
      vt[8]  = '{1'b1, A_CTRL, 32'h30,       4'hF, 32'h0};
      vt[9]  = '{1'b0, A_CTRL, 32'h0,        4'hF, 32'h30};
      vt[10] = '{1'b1, A_CTRL, 32'h06,       4'hF, 32'h0};
      vt[11] = '{1'b0, A_CTRL, 32'h0,        4'hF, 32'h0};
      vt[12] = '{1'b1, A_TO,   32'h001E8480, 4'hF, 32'h0};
      vt[13] = '{1'b0, A_TO,   32'h0,        4'hF, 32'h001E8480};

      repeat (3) @(negedge clk);
      check("reset_intr", {31'd0, intr}, 32'd0);
      check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
      check("reset_dat", wb_dat_o, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         xfer(vt[i].we, vt[i].idx, vt[i].dat, vt[i].sel, d);
         if (!vt[i].we) check($sformatf("reg_vec[%0d]", i), d, vt[i].exp);
      end

      // Basic 5800-cycle measurement with interrupt
      wr(A_CTRL, 32'h11);
      fork
         begin
            repeat (200) @(negedge clk);
            echo_i = 1'b1;
            repeat (5800) @(negedge clk);
            echo_i = 1'b0;
         end
         begin
            repeat (1000) @(negedge clk);
            rd_chk("busy_mid_pulse", A_CTRL, 32'h18);
         end
      join
      repeat (10) @(negedge clk);
      check("intr_done", {31'd0, intr}, 32'd1);
      rd_chk("ctrl_done", A_CTRL, 32'h12);
      rd_chk("width_5800", A_WID, 32'd5800);
      check("intr_cleared", {31'd0, intr}, 32'd0);
      rd_chk("ctrl_after_wread", A_CTRL, 32'h10);

      // Timeout with no echo
      wr(A_TO, 32'd1000);
      wr(A_CTRL, 32'h01);
      t0 = last_ack;
      repeat (990) @(negedge clk);
      seen = 1'b0;
      delta = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         xfer(1'b0, A_CTRL, 32'd0, 4'hF, d);
         if (!d[3]) begin
            seen = 1'b1;
            delta = last_ack - t0;
         end
      end
      check("busy_drop_seen", {31'd0, seen}, 32'd1);
      check("busy_drop_window",
            {31'd0, (delta >= 1002 && delta <= 1003)}, 32'd1);
      rd_chk("ctrl_timeout", A_CTRL, 32'h06);
      rd_chk("width_timeout", A_WID, 32'hFFFFFFFF);
      rd_chk("ctrl_to_after_wread", A_CTRL, 32'h04);

      // Auto-arm from trig_i falling edge; later trig ignored
      wr(A_TO, 32'h001E8480);
      wr(A_CTRL, 32'h30);
      repeat (5) @(negedge clk);
      trig_i = 1'b1;
      repeat (500) @(negedge clk);
      trig_i = 1'b0;
      repeat (20) @(negedge clk);
      fork
         begin
            echo_i = 1'b1;
            repeat (1200) @(negedge clk);
            echo_i = 1'b0;
         end
         begin
            repeat (600) @(negedge clk);
            trig_i = 1'b1;
            repeat (50) @(negedge clk);
            trig_i = 1'b0;
         end
      join
      repeat (10) @(negedge clk);
      check("intr_auto", {31'd0, intr}, 32'd1);
      rd_chk("ctrl_auto", A_CTRL, 32'h32);
      rd_chk("width_auto", A_WID, 32'd1200);
      wr(A_CTRL, 32'h00);

      // Echo already high at arm: truncated pulse is skipped
      echo_i = 1'b1;
      repeat (10) @(negedge clk);
      wr(A_CTRL, 32'h01);
      repeat (50) @(negedge clk);
      echo_i = 1'b0;
      repeat (250) @(negedge clk);
      echo_i = 1'b1;
      repeat (400) @(negedge clk);
      echo_i = 1'b0;
      repeat (10) @(negedge clk);
      rd_chk("ctrl_prehigh", A_CTRL, 32'h02);
      rd_chk("width_prehigh", A_WID, 32'd400);

      // Shrinking TIMEOUT mid-measurement forces an immediate timeout
      wr(A_CTRL, 32'h01);
      repeat (20) @(negedge clk);
      echo_i = 1'b1;
      repeat (300) @(negedge clk);
      wr(A_TO, 32'd100);
      repeat (5) @(negedge clk);
      echo_i = 1'b0;
      repeat (5) @(negedge clk);
      rd_chk("timeout_reg_100", A_TO, 32'd100);
      rd_chk("ctrl_shrink", A_CTRL, 32'h06);
      rd_chk("width_shrink", A_WID, 32'hFFFFFFFF);

      // Reset during MEASURE
      wr(A_TO, 32'h5000);
      wr(A_CTRL, 32'h31);
      repeat (20) @(negedge clk);
      echo_i = 1'b1;
      repeat (103) @(negedge clk);
      reset = 1'b1;
      echo_i = 1'b0;
      #1;
      check("rst_mid_intr", {31'd0, intr}, 32'd0);
      check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst_mid_dat", wb_dat_o, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rd_chk("rst_mid_ctrl", A_CTRL, 32'h0);
      rd_chk("rst_mid_width", A_WID, 32'h0);
      rd_chk("rst_mid_timeout", A_TO, 32'h001E8480);
      rd_chk("rst_mid_count", A_CNT, 32'h0);
      wr(A_CTRL, 32'h01);
      repeat (30) @(negedge clk);
      echo_i = 1'b1;
      repeat (700) @(negedge clk);
      echo_i = 1'b0;
      repeat (10) @(negedge clk);
      rd_chk("ctrl_after_rst", A_CTRL, 32'h02);
      rd_chk("width_700", A_WID, 32'd700);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
